tpu_host_loader: RTL and testbench

- Host-side front end that sits directly upstream of the tpu top level.
- Accepts a framed byte stream over a valid/ready handshake and decodes each frame header.
- Drives the tpu byte bus `ui_in` together with the matching `fetch_w`, `fetch_inp` or `fetch_ins` flag, and issues `start`.
- Captures the tpu `wire_out` result bytes into a local buffer and returns them to the host over a second valid/ready handshake.

---
 rtl/tpu_host_loader_if.sv | 32 +++
 rtl/tpu_host_loader.sv | 138 +++++++++++++
 tb/tb_tpu_host_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_host_loader_if.sv
// Host loader bus bundle: host input stream, host result stream and the
// byte/flag/start bus toward the tpu, plus loader status outputs.
interface tpu_host_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ui_in;
    logic       fetch_w;
    logic       fetch_inp;
    logic       fetch_ins;
    logic       start;
    logic [7:0] tpu_out;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    // Host / tpu-model side
    modport master (
        output in_data, in_valid, tpu_out, out_ready,
        input  in_ready, ui_in, fetch_w, fetch_inp, fetch_ins, start,
               out_data, out_valid, busy, done
    );

    // Loader side
    modport slave (
        input  in_data, in_valid, tpu_out, out_ready,
        output in_ready, ui_in, fetch_w, fetch_inp, fetch_ins, start,
               out_data, out_valid, busy, done
    );
endinterface

// File: rtl/tpu_host_loader.sv
// Host-side front end for the tpu: decodes framed host bytes into the tpu
// byte bus with fetch flags, issues start, captures result bytes from the
// tpu after a fixed delay and streams them back to the host.
module tpu_host_loader #(
    parameter int CAP_DELAY    = 12,
    parameter int RESULT_BYTES = 4
) (
    input logic              clk,
    input logic              reset,
    tpu_host_loader_if.slave bus
);
    localparam int IDX_W = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RESULT_BYTES - 1);
    localparam logic [7:0]       WAIT_LAST = 8'(CAP_DELAY - 1);

    typedef enum logic [2:0] {
        IDLE, PAYLOAD, START, WAIT, CAPTURE, DRAIN
    } state_t;

    state_t           state;
    logic [1:0]       frame_type;
    logic [5:0]       remaining;
    logic [7:0]       wait_cnt;
    logic [IDX_W-1:0] cap_idx;
    logic [IDX_W-1:0] drain_idx;
    logic [7:0]       result_buf [RESULT_BYTES];
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    // Frame decode, run sequencing, result capture and drain; all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            frame_type    <= 2'b00;
            remaining     <= '0;
            wait_cnt      <= '0;
            cap_idx       <= '0;
            drain_idx     <= '0;
            bus.in_ready  <= 1'b1;
            bus.ui_in     <= '0;
            bus.fetch_w   <= 1'b0;
            bus.fetch_inp <= 1'b0;
            bus.fetch_ins <= 1'b0;
            bus.start     <= 1'b0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            for (int i = 0; i < RESULT_BYTES; i++) begin
                result_buf[i] <= '0;
            end
        end else begin
            // Flag and pulse outputs are single-cycle unless re-asserted below
            bus.fetch_w   <= 1'b0;
            bus.fetch_inp <= 1'b0;
            bus.fetch_ins <= 1'b0;
            bus.start     <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        if (bus.in_data[7:6] == 2'b11) begin
                            state        <= START;
                            bus.start    <= 1'b1;
                            bus.in_ready <= 1'b0;
                            bus.busy     <= 1'b1;
                        end else if (bus.in_data[5:0] != 6'd0) begin
                            state      <= PAYLOAD;
                            frame_type <= bus.in_data[7:6];
                            remaining  <= bus.in_data[5:0];
                            bus.busy   <= 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (in_fire) begin
                        bus.ui_in <= bus.in_data;
                        case (frame_type)
                            2'b00:   bus.fetch_w   <= 1'b1;
                            2'b01:   bus.fetch_inp <= 1'b1;
                            default: bus.fetch_ins <= 1'b1;
                        endcase
                        remaining <= remaining - 6'd1;
                        if (remaining == 6'd1) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                START: begin
                    // Cycle after start is offset 1 from the start cycle
                    wait_cnt <= 8'd1;
                    cap_idx  <= '0;
                    if (CAP_DELAY == 1) begin
                        state <= CAPTURE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (wait_cnt == WAIT_LAST) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    result_buf[cap_idx] <= bus.tpu_out;
                    cap_idx             <= cap_idx + 1'b1;
                    if (cap_idx == LAST_IDX) begin
                        state         <= DRAIN;
                        drain_idx     <= '0;
                        bus.out_valid <= 1'b1;
                        // With a single result byte, buffer[0] is being written this edge
                        bus.out_data  <= (cap_idx == '0) ? bus.tpu_out : result_buf[0];
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (drain_idx == LAST_IDX) begin
                            state         <= IDLE;
                            bus.out_valid <= 1'b0;
                            bus.done      <= 1'b1;
                            bus.busy      <= 1'b0;
                            bus.in_ready  <= 1'b1;
                        end else begin
                            drain_idx    <= drain_idx + 1'b1;
                            bus.out_data <= result_buf[drain_idx + 1'b1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_host_loader.sv
// Directed bench for tpu_host_loader with scoreboard queues for the tpu
// byte bus and the host result stream, plus a simple tpu timing model.
module tb_tpu_host_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;

    tpu_host_loader_if bus ();

    tpu_host_loader #(.CAP_DELAY(12), .RESULT_BYTES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [2:0] flags;
    } bus_item_t;

    bus_item_t  exp_bus [$];
    logic [7:0] exp_out [$];

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int fw_cnt = 0;
    int fi_cnt = 0;
    int fs_cnt = 0;

    logic [7:0] base = 8'h10;
    logic [7:0] tpu_n = 8'd0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data = 8'd0;

    localparam logic [2:0] FL_W   = 3'b100;
    localparam logic [2:0] FL_INP = 3'b010;
    localparam logic [2:0] FL_INS = 3'b001;

    // Free-running clock
    always #5 clk = ~clk;

    // tpu model: result bus shows base+n in cycle T+n after the start cycle T
    always @(posedge clk) tpu_n <= bus.start ? 8'd1 : tpu_n + 8'd1;
    assign bus.tpu_out = bus.start ? base : base + tpu_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Monitor: compares bus and result traffic against the scoreboard queues
    always @(negedge clk) begin
        logic [2:0] fl;
        bus_item_t  it;
        logic [7:0] eo;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            fl = {bus.fetch_w, bus.fetch_inp, bus.fetch_ins};
            if (bus.fetch_w)   fw_cnt++;
            if (bus.fetch_inp) fi_cnt++;
            if (bus.fetch_ins) fs_cnt++;
            if (fl != 3'b000) begin
                if (exp_bus.size() == 0) begin
                    check("bus_unexpected", {29'd0, fl}, 32'd0);
                end else begin
                    it = exp_bus.pop_front();
                    check("ui_in", {24'd0, bus.ui_in}, {24'd0, it.data});
                    check("fetch_flags", {29'd0, fl}, {29'd0, it.flags});
                end
            end
            if (bus.start) begin
                start_cnt++;
                check("start_exclusive", {29'd0, fl}, 32'd0);
            end
            if (stall_prev) begin
                check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                check("stall_data", {24'd0, bus.out_data}, {24'd0, prev_data});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_out.size() == 0) begin
                    check("out_unexpected", {24'd0, bus.out_data}, 32'hFFFF);
                end else begin
                    eo = exp_out.pop_front();
                    check("out_data", {24'd0, bus.out_data}, {24'd0, eo});
                end
            end
            if (bus.done) begin
                done_cnt++;
                check("done_after_last", exp_out.size(), 32'd0);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    // Present one byte, wait for acceptance; in_valid is left high for bursts
    task automatic send_byte(input logic [7:0] b, input logic [2:0] fl, input bit is_payload);
        int k;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        k = 0;
        while (!bus.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 32'd0, 32'd1);
        end else if (is_payload) begin
            exp_bus.push_back('{data: b, flags: fl});
        end
        @(posedge clk);
        #1;
    endtask

    // Issue a run frame and drain its results, optionally toggling out_ready
    task automatic run_frame(input logic [7:0] b, input bit toggle);
        int s0;
        int d0;
        int k;
        base = b;
        for (int i = 0; i < 4; i++) exp_out.push_back(b + 8'd12 + 8'(i));
        s0 = start_cnt;
        d0 = done_cnt;
        bus.out_ready = toggle ? 1'b0 : 1'b1;
        send_byte(8'hC0, 3'b000, 1'b0);
        bus.in_valid = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 300) begin
            if (bus.busy) check("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk);
            #1;
            if (toggle) bus.out_ready = ~bus.out_ready;
            k++;
        end
        check("run_done_seen", done_cnt - d0, 32'd1);
        check("run_queue_empty", exp_out.size(), 32'd0);
        check("run_start_once", start_cnt - s0, 32'd1);
        check("run_busy_after", {31'd0, bus.busy}, 32'd0);
        check("run_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("run_done_single", done_cnt - d0, 32'd1);
        bus.out_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ui_in"}, {24'd0, bus.ui_in}, 32'd0);
        check({tag, "_flags"}, {29'd0, bus.fetch_w, bus.fetch_inp, bus.fetch_ins}, 32'd0);
        check({tag, "_start"}, {31'd0, bus.start}, 32'd0);
        check({tag, "_out"}, {22'd0, bus.out_valid, bus.done, bus.out_data}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Directed test sequence
    initial begin
        int w0;
        int i0;
        int s0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Weights frame, continuous valid
        w0 = fw_cnt; i0 = fi_cnt; s0 = fs_cnt;
        send_byte(8'h02, 3'b000, 1'b0);
        send_byte(8'hA1, FL_W, 1'b1);
        send_byte(8'hB2, FL_W, 1'b1);
        bus.in_valid = 1'b0;
        check("w_busy_end", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        check("w_flags_idle", {29'd0, bus.fetch_w, bus.fetch_inp, bus.fetch_ins}, 32'd0);
        check("w_ui_hold", {24'd0, bus.ui_in}, 32'hB2);
        check("w_count", fw_cnt - w0, 32'd2);

        // Inputs frame with a two-cycle valid gap
        w0 = fw_cnt; i0 = fi_cnt; s0 = fs_cnt;
        send_byte(8'h43, 3'b000, 1'b0);
        send_byte(8'h01, FL_INP, 1'b1);
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("gap_flags", {29'd0, bus.fetch_w, bus.fetch_inp, bus.fetch_ins}, 32'd0);
            check("gap_ui_hold", {24'd0, bus.ui_in}, 32'h01);
        end
        send_byte(8'h02, FL_INP, 1'b1);
        send_byte(8'h03, FL_INP, 1'b1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("inp_count", fi_cnt - i0, 32'd3);
        check("inp_other_flags", (fw_cnt - w0) + (fs_cnt - s0), 32'd0);

        // Empty instruction frame, then one-byte instruction frame back to back
        w0 = fw_cnt; i0 = fi_cnt; s0 = fs_cnt;
        send_byte(8'h80, 3'b000, 1'b0);
        check("empty_busy", {31'd0, bus.busy}, 32'd0);
        send_byte(8'h81, 3'b000, 1'b0);
        send_byte(8'h5C, FL_INS, 1'b1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("ins_count", fs_cnt - s0, 32'd1);
        check("ins_other_flags", (fw_cnt - w0) + (fi_cnt - i0), 32'd0);
        check("bus_queue_empty", exp_bus.size(), 32'd0);

        // Runs: free-flowing host, then a stalling host
        run_frame(8'h10, 1'b0);
        check("run_ui_untouched", {24'd0, bus.ui_in}, 32'h5C);
        run_frame(8'h30, 1'b1);

        // Reset during WAIT aborts the run
        base = 8'h70;
        send_byte(8'hC0, 3'b000, 1'b0);
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("wait_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_frame(8'h50, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
